// File: rtl/gcn_accum_matrix_mem.sv
// Purpose : ROWS x COLS row-accumulating matrix store for the GCN aggregation stage.
// Latency : writes commit at the accepting edge; reads return one cycle after i_rd_en.
// Backpres: o_wr_ready is 1 in IDLE, so writes are never stalled there. It is 0 for the ROWS-cycle clear sweep.
//
// Ports
//   i_clk / i_rst       rising-edge clock; asynchronous active-low reset
//   i_wr_*  o_wr_ready  valid/ready row write. i_wr_acc=1 adds into the row; 0 overwrites it.
//   i_rd_*  o_rd_*      registered row read. An out-of-range row returns zeros.
//   i_clear_req o_busy  starts the zeroing sweep; o_busy is high while the sweep runs.
//   o_row_written       bit r is set once row r has accepted a write since the last clear.
//   o_wr_err            sticky flag: a write to a row >= ROWS was dropped.
//   o_sat_flag          sticky flag: an accumulate was clamped (only with saturation built in).
//
// Build option: define ACCUM_SAT_EN to make accumulates saturate to the signed max/min.
//               By default accumulates wrap and o_sat_flag is tied to 0.
module gcn_accum_matrix_mem #(
   parameter int ROWS       = 6,
   parameter int COLS       = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ROW_WIDTH  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic [ROW_WIDTH-1:0]  i_wr_row,
   input  logic                  i_wr_acc,
   input  logic [DATA_WIDTH-1:0] i_wr_data [0:COLS-1],
   input  logic                  i_rd_en,
   input  logic [ROW_WIDTH-1:0]  i_rd_row,
   output logic [DATA_WIDTH-1:0] o_rd_data [0:COLS-1],
   output logic                  o_rd_valid,
   input  logic                  i_clear_req,
   output logic                  o_busy,
   output logic [ROWS-1:0]       o_row_written,
   output logic                  o_wr_err,
   output logic                  o_sat_flag
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ROW_WIDTH-1:0]  r_clr_ptr;
   logic [DATA_WIDTH-1:0] r_mem     [0:ROWS-1][0:COLS-1];
   logic [DATA_WIDTH-1:0] r_rd_data [0:COLS-1];
   logic                  r_rd_valid;
   logic [ROWS-1:0]       r_row_written;
   logic                  r_wr_err;

   logic                  w_wr_fire;
   logic                  w_wr_row_ok;
   logic                  w_rd_row_ok;
   logic                  w_wr_en;
   logic                  w_clr_last;
   logic [DATA_WIDTH-1:0] w_cur_row [0:COLS-1];
   logic [DATA_WIDTH-1:0] w_new_row [0:COLS-1];

   assign w_wr_row_ok = (int'(i_wr_row) < ROWS);
   assign w_rd_row_ok = (int'(i_rd_row) < ROWS);
   assign w_wr_fire   = i_wr_valid & o_wr_ready;
   assign w_wr_en     = w_wr_fire & w_wr_row_ok;
   assign w_clr_last  = (r_state == S_CLEAR) && (r_clr_ptr == ROW_WIDTH'(ROWS - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_wr_ready  = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_wr_ready = 1'b1;
            if (i_clear_req) begin
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            o_busy = 1'b1;
            if (w_clr_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The sweep pointer rests at 0 outside CLEAR, so every sweep starts at row 0.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_clr_ptr <= '0;
      end else if (r_state == S_CLEAR) begin
         r_clr_ptr <= r_clr_ptr + 1'b1;
      end else begin
         r_clr_ptr <= '0;
      end
   end

   // ---------------- Write datapath ----------------
   // The read half of the read-modify-write is combinational. A back-to-back accumulate
   // into the same row therefore always sees the previous write.
   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         w_cur_row[c] = w_wr_row_ok ? r_mem[i_wr_row][c] : '0;
      end
   end

`ifdef ACCUM_SAT_EN
   logic [DATA_WIDTH:0] w_ext_sum [0:COLS-1];
   logic                w_sat_any;
   logic                r_sat_flag;

   // The sum is widened by one bit. Overflow shows as the top two bits disagreeing,
   // and the top bit gives the true sign, which selects the clamp direction.
   always_comb begin
      w_sat_any = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         w_ext_sum[c] = {w_cur_row[c][DATA_WIDTH-1], w_cur_row[c]}
                      + {i_wr_data[c][DATA_WIDTH-1], i_wr_data[c]};
         w_new_row[c] = i_wr_data[c];
         if (i_wr_acc) begin
            if (w_ext_sum[c][DATA_WIDTH] != w_ext_sum[c][DATA_WIDTH-1]) begin
               w_sat_any    = 1'b1;
               w_new_row[c] = w_ext_sum[c][DATA_WIDTH]
                            ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else begin
               w_new_row[c] = w_ext_sum[c][DATA_WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sat_flag <= 1'b0;
      end else if (w_clr_last) begin
         r_sat_flag <= 1'b0;
      end else if (w_wr_en && i_wr_acc && w_sat_any) begin
         r_sat_flag <= 1'b1;
      end
   end

   assign o_sat_flag = r_sat_flag;
`else
   // Two's-complement add that wraps modulo 2^DATA_WIDTH.
   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         w_new_row[c] = i_wr_acc ? (w_cur_row[c] + i_wr_data[c]) : i_wr_data[c];
      end
   end

   assign o_sat_flag = 1'b0;
`endif

   // Writes are blocked in CLEAR (wr_ready=0), so the sweep and writes never collide.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               r_mem[r][c] <= '0;
            end
         end
      end else if (r_state == S_CLEAR) begin
         for (int c = 0; c < COLS; c++) begin
            r_mem[r_clr_ptr][c] <= '0;
         end
      end else if (w_wr_en) begin
         for (int c = 0; c < COLS; c++) begin
            r_mem[i_wr_row][c] <= w_new_row[c];
         end
      end
   end

   // ---------------- Status ----------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_row_written <= '0;
         r_wr_err      <= 1'b0;
      end else if (w_clr_last) begin
         r_row_written <= '0;
         r_wr_err      <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_row_written[i_wr_row] <= 1'b1;
         end
         if (w_wr_fire && !w_wr_row_ok) begin
            r_wr_err <= 1'b1;
         end
      end
   end

   assign o_row_written = r_row_written;
   assign o_wr_err      = r_wr_err;

   // ---------------- Read port ----------------
   // The read samples the array before this edge's write lands, so a same-row
   // read and write in one cycle returns the old contents.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rd_valid <= 1'b0;
         for (int c = 0; c < COLS; c++) begin
            r_rd_data[c] <= '0;
         end
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            for (int c = 0; c < COLS; c++) begin
               r_rd_data[c] <= w_rd_row_ok ? r_mem[i_rd_row][c] : '0;
            end
         end
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_gcn_accum_matrix_mem.sv
module tb_gcn_accum_matrix_mem;

   localparam int ROWS = 6;
   localparam int COLS = 3;
   localparam int DW   = 16;

   typedef logic [COLS-1:0][DW-1:0] row_t;

   typedef struct {
      logic       wv;
      logic [2:0] wrow;
      logic       acc;
      row_t       wd;
      logic       re;
      logic [2:0] rrow;
      row_t       ed;    // expected read data, returned one cycle later
      logic [5:0] erw;   // expected row_written after the edge
      logic       eerr;  // expected wr_err after the edge
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic [2:0]    wr_row;
   logic          wr_acc;
   logic [DW-1:0] wr_data [0:COLS-1];
   logic          rd_en;
   logic [2:0]    rd_row;
   logic [DW-1:0] rd_data [0:COLS-1];
   logic          rd_valid;
   logic          clear_req;
   logic          busy;
   logic [5:0]    row_written;
   logic          wr_err;
   logic          sat_flag;

   int   n_cmp  = 0;
   int   n_fail = 0;
   row_t exp_q [$];
   vec_t tbl [0:14];

   gcn_accum_matrix_mem #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_row(wr_row),
      .i_wr_acc(wr_acc), .i_wr_data(wr_data),
      .i_rd_en(rd_en), .i_rd_row(rd_row), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
      .i_clear_req(clear_req), .o_busy(busy), .o_row_written(row_written),
      .o_wr_err(wr_err), .o_sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic row_t r3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
      row_t v;
      v[0] = a; v[1] = b; v[2] = c;
      return v;
   endfunction

   function automatic vec_t mk(input logic wv, input logic [2:0] wrow, input logic acc, input row_t wd,
                               input logic re, input logic [2:0] rrow, input row_t ed,
                               input logic [5:0] erw, input logic eerr);
      vec_t v;
      v.wv = wv; v.wrow = wrow; v.acc = acc; v.wd = wd;
      v.re = re; v.rrow = rrow; v.ed = ed; v.erw = erw; v.eerr = eerr;
      return v;
   endfunction

   task automatic idle();
      wr_valid  = 1'b0;
      wr_row    = '0;
      wr_acc    = 1'b0;
      rd_en     = 1'b0;
      rd_row    = '0;
      clear_req = 1'b0;
      for (int c = 0; c < COLS; c++) wr_data[c] = '0;
   endtask

   task automatic set_wr(input logic [2:0] row, input logic acc, input row_t d);
      wr_valid = 1'b1;
      wr_row   = row;
      wr_acc   = acc;
      for (int c = 0; c < COLS; c++) wr_data[c] = d[c];
   endtask

   task automatic set_rd(input logic [2:0] row, input row_t e);
      rd_en  = 1'b1;
      rd_row = row;
      exp_q.push_back(e);
   endtask

   // Apply the driven inputs across one rising edge, then return to idle at edge+1.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   // Scoreboard: each read response is matched against the oldest pushed expectation.
   always @(negedge clk) begin
      if (rd_valid) begin
         row_t e;
         if (exp_q.size() == 0) begin
            chk("rd_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < COLS; c++) chk($sformatf("rd_data[%0d]", c), 32'(rd_data[c]), 32'(e[c]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      row_t z;
      z = r3(16'd0, 16'd0, 16'd0);

      tbl[0]  = mk(0, 3'd0, 0, z,                             1, 3'd2, z,                             6'b000000, 0);
      tbl[1]  = mk(1, 3'd2, 1, r3(16'd1, 16'd2, 16'd3),       0, 3'd0, z,                             6'b000100, 0);
      tbl[2]  = mk(1, 3'd2, 1, r3(16'd1, 16'd2, 16'd3),       0, 3'd0, z,                             6'b000100, 0);
      tbl[3]  = mk(0, 3'd0, 0, z,                             1, 3'd2, r3(16'd2, 16'd4, 16'd6),       6'b000100, 0);
      tbl[4]  = mk(1, 3'd0, 0, r3(16'd5, 16'd5, 16'd5),       0, 3'd0, z,                             6'b000101, 0);
      tbl[5]  = mk(1, 3'd0, 0, r3(16'd7, 16'd0, 16'hFFFF),    1, 3'd0, r3(16'd5, 16'd5, 16'd5),       6'b000101, 0);
      tbl[6]  = mk(0, 3'd0, 0, z,                             1, 3'd0, r3(16'd7, 16'd0, 16'hFFFF),    6'b000101, 0);
      tbl[7]  = mk(1, 3'd7, 1, r3(16'd9, 16'd9, 16'd9),       0, 3'd0, z,                             6'b000101, 1);
      tbl[8]  = mk(0, 3'd0, 0, z,                             1, 3'd7, z,                             6'b000101, 1);
      tbl[9]  = mk(1, 3'd1, 1, r3(16'd10, 16'd20, 16'd30),    1, 3'd1, z,                             6'b000111, 1);
      tbl[10] = mk(1, 3'd1, 1, r3(16'hFFF6, 16'd1, 16'd1),    1, 3'd1, r3(16'd10, 16'd20, 16'd30),    6'b000111, 1);
      tbl[11] = mk(0, 3'd0, 0, z,                             1, 3'd1, r3(16'd0, 16'd21, 16'd31),     6'b000111, 1);
      tbl[12] = mk(1, 3'd3, 0, r3(16'h7FFF, 16'h8000, 16'd100), 0, 3'd0, z,                           6'b001111, 1);
      tbl[13] = mk(1, 3'd3, 1, r3(16'd1, 16'hFFFF, 16'hFF38),  1, 3'd3, r3(16'h7FFF, 16'h8000, 16'd100), 6'b001111, 1);
`ifdef ACCUM_SAT_EN
      tbl[14] = mk(0, 3'd0, 0, z,                             1, 3'd3, r3(16'h7FFF, 16'h8000, 16'hFF9C), 6'b001111, 1);
`else
      tbl[14] = mk(0, 3'd0, 0, z,                             1, 3'd3, r3(16'h8000, 16'h7FFF, 16'hFF9C), 6'b001111, 1);
`endif

      // ---- reset state ----
      idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_row_written", 32'(row_written), 32'd0);
      chk("rst_wr_err", 32'(wr_err), 32'd0);
      chk("rst_sat_flag", 32'(sat_flag), 32'd0);
      for (int c = 0; c < COLS; c++) chk("rst_rd_data", 32'(rd_data[c]), 32'd0);
      rst = 1'b1;
      step();
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);

      // ---- table-driven writes/reads ----
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].wv) set_wr(tbl[i].wrow, tbl[i].acc, tbl[i].wd);
         if (tbl[i].re) set_rd(tbl[i].rrow, tbl[i].ed);
         step();
         chk($sformatf("row_written[v%0d]", i), 32'(row_written), 32'(tbl[i].erw));
         chk($sformatf("wr_err[v%0d]", i), 32'(wr_err), 32'(tbl[i].eerr));
      end
      step();
`ifdef ACCUM_SAT_EN
      chk("sat_flag", 32'(sat_flag), 32'd1);
`else
      chk("sat_flag", 32'(sat_flag), 32'd0);
`endif

      // ---- clear sweep; a write in the same cycle as clear_req is still accepted ----
      clear_req = 1'b1;
      set_wr(3'd4, 1'b0, r3(16'd4, 16'd4, 16'd4));
      step();
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_wr_ready", 32'(wr_ready), 32'd0);
      chk("clr_row_written", 32'(row_written), 32'(6'b011111));
      n = 1;
      // Row 4 is swept last but one, so it still holds its data here; clear_req is ignored.
      set_rd(3'd4, r3(16'd4, 16'd4, 16'd4));
      clear_req = 1'b1;
      step();
      while (busy && n < 20) begin
         n++;
         step();
      end
      chk("clr_busy_cycles", 32'(n), 32'd6);
      chk("clr_done_row_written", 32'(row_written), 32'd0);
      chk("clr_done_wr_err", 32'(wr_err), 32'd0);
      chk("clr_done_sat_flag", 32'(sat_flag), 32'd0);
      chk("clr_done_wr_ready", 32'(wr_ready), 32'd1);
      for (int r = 0; r < ROWS; r++) begin
         set_rd(3'(r), z);
         step();
      end
      step();

      // ---- reset in the middle of a sweep ----
      set_wr(3'd5, 1'b0, r3(16'd1, 16'd1, 16'd1));
      step();
      chk("mid_row_written", 32'(row_written), 32'(6'b100000));
      clear_req = 1'b1;
      step();
      repeat (3) step();
      chk("mid_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_row_written", 32'(row_written), 32'd0);
      chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();
      chk("mid_wr_ready", 32'(wr_ready), 32'd1);
      chk("mid_busy_after", 32'(busy), 32'd0);
      set_rd(3'd5, z);
      step();
      step();

      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
